sys_mng_alarm_monitor: RTL and testbench

Consumes the continuously refreshed System Monitor readings (temperature, VCCINT, VCCAUX, VCCBRAM) produced by the DRP controller/wrapper stage. It periodically samples them and compares each 12-bit code against compile-time upper/lower limits with hysteresis and debounce. It drives level alarms, sticky status, an interrupt pulse and a latched over-temperature shutdown request to board-management logic.

---
 rtl/sys_mng_pkg.sv | 32 +++
 rtl/sys_mng_alarm_monitor.sv | 194 +++++++++++++++++++
 tb/tb_sys_mng_alarm_monitor.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sys_mng_pkg.sv
// Shared definitions for the System Monitor alarm logic: channel indices,
// ADC code width, scan FSM states and the default alarm limits.
package sys_mng_pkg;

  localparam int unsigned ADC_W  = 12;
  localparam int unsigned RAW_W  = 16;
  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] CH_TEMP    = 2'd0;
  localparam logic [1:0] CH_VCCINT  = 2'd1;
  localparam logic [1:0] CH_VCCAUX  = 2'd2;
  localparam logic [1:0] CH_VCCBRAM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_EVAL,
    ST_DONE
  } state_t;

  // Default limits in 12-bit ADC codes
  localparam logic [ADC_W-1:0] DEF_TEMP_UPPER    = 12'hB79;  // ~85 C
  localparam logic [ADC_W-1:0] DEF_TEMP_LOWER    = 12'h000;  // disabled
  localparam logic [ADC_W-1:0] DEF_TEMP_CRIT     = 12'hBF2;  // ~100 C
  localparam logic [ADC_W-1:0] DEF_VCCINT_UPPER  = 12'h4AC;
  localparam logic [ADC_W-1:0] DEF_VCCINT_LOWER  = 12'h466;
  localparam logic [ADC_W-1:0] DEF_VCCAUX_UPPER  = 12'hA14;
  localparam logic [ADC_W-1:0] DEF_VCCAUX_LOWER  = 12'h91F;
  localparam logic [ADC_W-1:0] DEF_VCCBRAM_UPPER = 12'h4AC;
  localparam logic [ADC_W-1:0] DEF_VCCBRAM_LOWER = 12'h466;

endpackage

// File: rtl/sys_mng_alarm_monitor.sv
// Periodic limit checker for System Monitor readings.
// Every SAMPLE_PERIOD clocks (while ENABLE) it snapshots the four readings and
// walks them through one shared comparator, applying debounce on assertion and
// hysteresis on release.
// Ports:
//   CLK, RESETN            clock, async active-low reset
//   ENABLE                 allow scans to start
//   TEMP/VCCINT/VCCAUX/VCCBRAM  raw 16-bit readings, code in [15:4], 0 = no data
//   STICKY_CLR             clears STICKY (a coincident set wins)
//   OVER/UNDER/ALARM       per-channel level alarms (bit0 TEMP .. bit3 VCCBRAM)
//   STICKY                 alarm history
//   IRQ                    one-cycle pulse after a scan that raised OVER/UNDER
//   SHUTDOWN_REQ           latched over-temperature request
module sys_mng_alarm_monitor
  import sys_mng_pkg::*;
#(
  parameter int unsigned      SAMPLE_PERIOD = 1000,
  parameter int unsigned      DEBOUNCE      = 3,
  parameter int unsigned      HYST          = 8,
  parameter logic [ADC_W-1:0] TEMP_UPPER    = DEF_TEMP_UPPER,
  parameter logic [ADC_W-1:0] TEMP_LOWER    = DEF_TEMP_LOWER,
  parameter logic [ADC_W-1:0] TEMP_CRIT     = DEF_TEMP_CRIT,
  parameter logic [ADC_W-1:0] VCCINT_UPPER  = DEF_VCCINT_UPPER,
  parameter logic [ADC_W-1:0] VCCINT_LOWER  = DEF_VCCINT_LOWER,
  parameter logic [ADC_W-1:0] VCCAUX_UPPER  = DEF_VCCAUX_UPPER,
  parameter logic [ADC_W-1:0] VCCAUX_LOWER  = DEF_VCCAUX_LOWER,
  parameter logic [ADC_W-1:0] VCCBRAM_UPPER = DEF_VCCBRAM_UPPER,
  parameter logic [ADC_W-1:0] VCCBRAM_LOWER = DEF_VCCBRAM_LOWER
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              ENABLE,
  input  logic [RAW_W-1:0]  TEMP,
  input  logic [RAW_W-1:0]  VCCINT,
  input  logic [RAW_W-1:0]  VCCAUX,
  input  logic [RAW_W-1:0]  VCCBRAM,
  input  logic              STICKY_CLR,
  output logic [NUM_CH-1:0] OVER,
  output logic [NUM_CH-1:0] UNDER,
  output logic [NUM_CH-1:0] ALARM,
  output logic [NUM_CH-1:0] STICKY,
  output logic              IRQ,
  output logic              SHUTDOWN_REQ
);

  localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DEB_W = 4;
  localparam int unsigned CMP_W = ADC_W + 1;

  // Reject parameter sets whose hysteresis windows would wrap
  if (SAMPLE_PERIOD < 8 || DEBOUNCE < 1 || DEBOUNCE > 15 ||
      32'(TEMP_UPPER) < HYST || 32'(VCCINT_UPPER) < HYST ||
      32'(VCCAUX_UPPER) < HYST || 32'(VCCBRAM_UPPER) < HYST ||
      32'(TEMP_LOWER) + HYST > 4095 || 32'(VCCINT_LOWER) + HYST > 4095 ||
      32'(VCCAUX_LOWER) + HYST > 4095 || 32'(VCCBRAM_LOWER) + HYST > 4095) begin : g_param_check
    $error("sys_mng_alarm_monitor: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tick_cnt_q;
  logic               tick_c;
  logic [1:0]         ch_q, ch_d;
  logic               rise_q, rise_d;
  logic               irq_d, shutdown_d;
  logic [RAW_W-1:0]   snap_q [NUM_CH];
  logic [DEB_W-1:0]   over_cnt_q [NUM_CH];
  logic [DEB_W-1:0]   under_cnt_q [NUM_CH];
  logic [DEB_W-1:0]   over_cnt_d [NUM_CH];
  logic [DEB_W-1:0]   under_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  over_d, under_d;
  logic [RAW_W-1:0]   raw_c;
  logic [ADC_W-1:0]   code_c, upper_c, lower_c;
  logic [CMP_W-1:0]   over_rel_c, under_rel_c;
  logic [DEB_W-1:0]   ocnt_c, ucnt_c;

  assign tick_c = (tick_cnt_q == CNT_W'(SAMPLE_PERIOD - 1));

  // Free-running scan timer
  always_ff @(posedge CLK or negedge RESETN) begin : p_tick
    if (!RESETN) tick_cnt_q <= '0;
    else         tick_cnt_q <= tick_c ? '0 : tick_cnt_q + CNT_W'(1);
  end

  // Shared comparator operands for the channel under evaluation
  always_comb begin : p_chan_sel
    raw_c   = snap_q[ch_q];
    code_c  = raw_c[RAW_W-1 -: ADC_W];
    upper_c = TEMP_UPPER;
    lower_c = TEMP_LOWER;
    case (ch_q)
      CH_VCCINT:  begin upper_c = VCCINT_UPPER;  lower_c = VCCINT_LOWER;  end
      CH_VCCAUX:  begin upper_c = VCCAUX_UPPER;  lower_c = VCCAUX_LOWER;  end
      CH_VCCBRAM: begin upper_c = VCCBRAM_UPPER; lower_c = VCCBRAM_LOWER; end
      default:    begin upper_c = TEMP_UPPER;    lower_c = TEMP_LOWER;    end
    endcase
    over_rel_c  = {1'b0, upper_c} - CMP_W'(HYST);
    under_rel_c = {1'b0, lower_c} + CMP_W'(HYST);
  end

  // Scan sequencing and per-channel debounce/hysteresis update
  always_comb begin : p_fsm_next
    state_d     = state_q;
    ch_d        = ch_q;
    rise_d      = rise_q;
    irq_d       = 1'b0;
    shutdown_d  = SHUTDOWN_REQ;
    over_d      = OVER;
    under_d     = UNDER;
    over_cnt_d  = over_cnt_q;
    under_cnt_d = under_cnt_q;
    ocnt_c      = over_cnt_q[ch_q];
    ucnt_c      = under_cnt_q[ch_q];

    case (state_q)
      ST_IDLE: begin
        if (tick_c && ENABLE) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ch_d    = '0;
        rise_d  = 1'b0;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        // An all-zero raw word means the monitor has not produced data yet
        if (raw_c != '0) begin
          if (code_c > upper_c) begin
            if (ocnt_c != DEB_W'(DEBOUNCE)) ocnt_c = ocnt_c + DEB_W'(1);
            if (ocnt_c == DEB_W'(DEBOUNCE)) over_d[ch_q] = 1'b1;
          end else begin
            ocnt_c = '0;
            if ({1'b0, code_c} < over_rel_c) over_d[ch_q] = 1'b0;
          end
          if (code_c < lower_c) begin
            if (ucnt_c != DEB_W'(DEBOUNCE)) ucnt_c = ucnt_c + DEB_W'(1);
            if (ucnt_c == DEB_W'(DEBOUNCE)) under_d[ch_q] = 1'b1;
          end else begin
            ucnt_c = '0;
            if ({1'b0, code_c} > under_rel_c) under_d[ch_q] = 1'b0;
          end
          over_cnt_d[ch_q]  = ocnt_c;
          under_cnt_d[ch_q] = ucnt_c;
          if (ch_q == CH_TEMP && code_c >= TEMP_CRIT) shutdown_d = 1'b1;
          rise_d = rise_q | (|((over_d & ~OVER) | (under_d & ~UNDER)));
        end
        if (ch_q == 2'(NUM_CH - 1)) state_d = ST_DONE;
        else                        ch_d    = ch_q + 2'd1;
      end
      ST_DONE: begin
        irq_d   = rise_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, snapshot and output registers
  always_ff @(posedge CLK or negedge RESETN) begin : p_regs
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      rise_q       <= 1'b0;
      OVER         <= '0;
      UNDER        <= '0;
      ALARM        <= '0;
      STICKY       <= '0;
      IRQ          <= 1'b0;
      SHUTDOWN_REQ <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i]      <= '0;
        over_cnt_q[i]  <= '0;
        under_cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      rise_q       <= rise_d;
      OVER         <= over_d;
      UNDER        <= under_d;
      ALARM        <= over_d | under_d;
      STICKY       <= (STICKY & ~{NUM_CH{STICKY_CLR}}) | ALARM;
      IRQ          <= irq_d;
      SHUTDOWN_REQ <= shutdown_d;
      over_cnt_q   <= over_cnt_d;
      under_cnt_q  <= under_cnt_d;
      if (state_q == ST_LATCH) begin
        snap_q[CH_TEMP]    <= TEMP;
        snap_q[CH_VCCINT]  <= VCCINT;
        snap_q[CH_VCCAUX]  <= VCCAUX;
        snap_q[CH_VCCBRAM] <= VCCBRAM;
      end
    end
  end

endmodule

// File: tb/tb_sys_mng_alarm_monitor.sv
// Self-checking bench for sys_mng_alarm_monitor with SAMPLE_PERIOD=16.
// Scan-level vectors run from a table through a scoreboard queue; hand
// sequences cover exact cycle timing, set-vs-clear, reset and ENABLE corners.
module tb_sys_mng_alarm_monitor;
  import sys_mng_pkg::*;

  localparam int P = 16;

  // Nominal (in-range) raw readings
  localparam logic [15:0] T_NOM = 16'h8000;
  localparam logic [15:0] I_NOM = 16'h4890;
  localparam logic [15:0] A_NOM = 16'h99A0;
  localparam logic [15:0] B_NOM = 16'h4890;

  logic        CLK = 1'b0;
  logic        RESETN, ENABLE, STICKY_CLR;
  logic [15:0] TEMP, VCCINT, VCCAUX, VCCBRAM;
  logic [3:0]  OVER, UNDER, ALARM, STICKY;
  logic        IRQ, SHUTDOWN_REQ;

  int cyc;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] temp, vint, vaux, vbram;
    logic        clr;
    logic [3:0]  over, under;
    logic        irq, sd;
    logic [3:0]  sticky;
  } vec_t;

  typedef struct {
    logic [3:0] over, under, alarm, sticky;
    logic       sd, irq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  sys_mng_alarm_monitor #(.SAMPLE_PERIOD(P), .DEBOUNCE(3)) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .ENABLE       (ENABLE),
    .TEMP         (TEMP),
    .VCCINT       (VCCINT),
    .VCCAUX       (VCCAUX),
    .VCCBRAM      (VCCBRAM),
    .STICKY_CLR   (STICKY_CLR),
    .OVER         (OVER),
    .UNDER        (UNDER),
    .ALARM        (ALARM),
    .STICKY       (STICKY),
    .IRQ          (IRQ),
    .SHUTDOWN_REQ (SHUTDOWN_REQ)
  );

  always #5 CLK = ~CLK;

  // Cycle index since reset release; ticks fall on cyc % P == P-1
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic goto_mod(input int m);
    @(negedge CLK);
    while (cyc % P != m) @(negedge CLK);
  endtask

  function automatic vec_t mk(input logic [15:0] t, input logic [15:0] i,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic clr, input logic [3:0] ov,
                              input logic [3:0] un, input logic irq,
                              input logic sd, input logic [3:0] st);
    vec_t v;
    v.temp = t; v.vint = i; v.vaux = a; v.vbram = b; v.clr = clr;
    v.over = ov; v.under = un; v.irq = irq; v.sd = sd; v.sticky = st;
    return v;
  endfunction

  // One scan: drive at t-5 (optional STICKY_CLR pulse), compare at t+8
  task automatic run_row(input vec_t v);
    exp_t e;
    int   t, irq_n, irq_at;
    goto_mod(10);
    t = cyc + 5;
    TEMP = v.temp; VCCINT = v.vint; VCCAUX = v.vaux; VCCBRAM = v.vbram;
    STICKY_CLR = v.clr;
    e.over = v.over; e.under = v.under; e.alarm = v.over | v.under;
    e.sticky = v.sticky; e.sd = v.sd; e.irq = v.irq;
    sb.push_back(e);
    irq_n = 0; irq_at = -1;
    while (cyc < t + 8) begin
      @(negedge CLK);
      STICKY_CLR = 1'b0;
      if (IRQ) begin irq_n++; irq_at = cyc; end
    end
    e = sb.pop_front();
    chk("over",     OVER,         e.over);
    chk("under",    UNDER,        e.under);
    chk("alarm",    ALARM,        e.alarm);
    chk("sticky",   STICKY,       e.sticky);
    chk("shutdown", SHUTDOWN_REQ, e.sd);
    chk("irq_cnt",  irq_n,        e.irq ? 1 : 0);
    chk("irq_cyc",  irq_at,       e.irq ? t + 7 : -1);
  endtask

  initial begin
    int t;
    RESETN = 1'b1; ENABLE = 1'b1; STICKY_CLR = 1'b0;
    TEMP = '0; VCCINT = '0; VCCAUX = '0; VCCBRAM = '0;

    // temp, vccint, vccaux, vccbram, clr, over, under, irq, sd, sticky
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(T_NOM,    I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(16'hB7A0, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
      vecs.push_back(mk(16'hB700, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    end
    vecs.push_back(mk(16'hB7A0, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(16'hB7A0, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(16'hB7A0, I_NOM, A_NOM, B_NOM, 0, 4'h1, 4'h0, 1, 0, 4'h1));
    vecs.push_back(mk(16'hB720, I_NOM, A_NOM, B_NOM, 0, 4'h1, 4'h0, 0, 0, 4'h1));
    vecs.push_back(mk(16'hB700, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h1));
    vecs.push_back(mk(T_NOM,    I_NOM, A_NOM, B_NOM, 1, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(T_NOM, I_NOM, 16'h91E0, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(T_NOM, I_NOM, 16'h91E0, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(T_NOM, I_NOM, 16'h91E0, B_NOM, 0, 4'h0, 4'h4, 1, 0, 4'h4));
    vecs.push_back(mk(T_NOM, I_NOM, 16'h9260, B_NOM, 0, 4'h0, 4'h4, 0, 0, 4'h4));
    vecs.push_back(mk(T_NOM, I_NOM, 16'h9280, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h4));
    vecs.push_back(mk(T_NOM, I_NOM, A_NOM,    B_NOM, 1, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(T_NOM, 16'h4AD0, A_NOM, 16'h4650, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(T_NOM, 16'h4AD0, A_NOM, 16'h4650, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(T_NOM, 16'h4AD0, A_NOM, 16'h4650, 0, 4'h2, 4'h8, 1, 0, 4'hA));
    vecs.push_back(mk(T_NOM, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'hA));
    vecs.push_back(mk(T_NOM, I_NOM, A_NOM, B_NOM, 1, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(16'hB7A0, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(16'hB7A0, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(16'h0000, I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h0));
    vecs.push_back(mk(16'hB7A0, I_NOM, A_NOM, B_NOM, 0, 4'h1, 4'h0, 1, 0, 4'h1));
    vecs.push_back(mk(T_NOM,    I_NOM, A_NOM, B_NOM, 0, 4'h0, 4'h0, 0, 0, 4'h1));
    vecs.push_back(mk(T_NOM,    I_NOM, A_NOM, B_NOM, 1, 4'h0, 4'h0, 0, 0, 4'h0));

    #2 RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_over",   OVER,         0);
    chk("rst_under",  UNDER,        0);
    chk("rst_alarm",  ALARM,        0);
    chk("rst_sticky", STICKY,       0);
    chk("rst_irq",    IRQ,          0);
    chk("rst_sd",     SHUTDOWN_REQ, 0);
    RESETN = 1'b1;

    foreach (vecs[i]) run_row(vecs[i]);

    // Critical temperature: no debounce, visible at t+3, latched afterwards
    goto_mod(10); t = cyc + 5; TEMP = 16'hBF20;
    goto(t + 2); chk("sd_t2", SHUTDOWN_REQ, 0);
    goto(t + 3); chk("sd_t3", SHUTDOWN_REQ, 1); TEMP = T_NOM;
    goto(t + 8); chk("sd_no_over", OVER, 0);
    goto_mod(10); t = cyc + 5;
    goto(t + 8); chk("sd_latched", SHUTDOWN_REQ, 1);

    // VCCBRAM over: snapshot isolation, channel-3 timing, set beats clear
    goto_mod(10); t = cyc + 5; VCCBRAM = 16'h4AD0;
    goto(t + 2); VCCBRAM = B_NOM;
    goto_mod(10); t = cyc + 5; VCCBRAM = 16'h4AD0;
    goto(t + 8); chk("bram_scan2", OVER, 0);
    goto_mod(10); t = cyc + 5;
    goto(t + 5); chk("ch3_t5", OVER, 4'h0);
    goto(t + 6); chk("ch3_t6", OVER, 4'h8); chk("alarm_t6", ALARM, 4'h8);
    chk("irq_t6", IRQ, 0); chk("sticky_t6", STICKY, 4'h0);
    STICKY_CLR = 1'b1;
    goto(t + 7); STICKY_CLR = 1'b0;
    chk("sticky_set_wins", STICKY, 4'h8); chk("irq_t7", IRQ, 1);
    goto(t + 8); chk("irq_t8", IRQ, 0);

    // Reset during EVAL
    goto_mod(10); t = cyc + 5;
    goto(t + 3);
    chk("pre_rst", {OVER, STICKY, SHUTDOWN_REQ}, {4'h8, 4'h8, 1'b1});
    RESETN = 1'b0;
    #1;
    chk("rst_mid", {OVER, UNDER, ALARM, STICKY, IRQ, SHUTDOWN_REQ}, 0);
    TEMP = 16'hBF20; VCCBRAM = B_NOM; VCCINT = I_NOM;
    @(negedge CLK); @(negedge CLK);
    RESETN = 1'b1;
    goto(17); chk("rst_scan_t2", SHUTDOWN_REQ, 0);
    goto(18); chk("rst_scan_t3", SHUTDOWN_REQ, 1);

    // Ticks with ENABLE low are dropped; a scan started while high completes
    goto(20); TEMP = T_NOM; ENABLE = 1'b0; VCCINT = 16'h4AD0;
    goto(70); chk("dis_over", OVER, 0);
    goto(74);  ENABLE = 1'b1;
    goto(81);  ENABLE = 1'b0;
    goto(90);  ENABLE = 1'b1;
    goto(97);  ENABLE = 1'b0;
    goto(106); ENABLE = 1'b1;
    goto(113); ENABLE = 1'b0;
    goto(114); chk("en_t3", OVER, 4'h0);
    goto(115); chk("en_t4", OVER, 4'h2); chk("sd_hold", SHUTDOWN_REQ, 1);
    goto(118); chk("en_irq_t7", IRQ, 1);
    goto(119); chk("en_irq_t8", IRQ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
